// File: rtl/eth_pcs_pkg.sv
// ----------------------------------------------------------------------------
// eth_pcs_pkg
//   Definitions shared by the 10G PCS receive-domain blocks.
//   - SYNC_DATA / SYNC_CTRL : the two legal 64b/66b sync header codes
//   - lock_state_t          : Clause 49 block-lock state encoding
//   - sh_is_valid()         : true for a legal sync header
// ----------------------------------------------------------------------------
package eth_pcs_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  typedef enum logic [1:0] {
    RESET_CNT = 2'd0,
    TEST_SH   = 2'd1,
    SLIP      = 2'd2,
    SLIP_WAIT = 2'd3
  } lock_state_t;

  function automatic logic sh_is_valid(input logic [1:0] hdr);
    return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/rx_block_lock_ctrl_if.sv
// ----------------------------------------------------------------------------
// rx_block_lock_ctrl_if
//   Gearbox <-> block-lock controller signal bundle.
//   - xver_rx_header       : sync header from the gearbox
//   - xver_rx_header_valid : header qualifier
//   - xver_rx_gearbox_slip : one-cycle slip request back to the gearbox
//   - o_block_lock         : alignment acquired
//   - o_slip_count         : saturating slip counter
//   master : gearbox / stimulus side, slave : lock controller side
// ----------------------------------------------------------------------------
interface rx_block_lock_ctrl_if;

  logic [1:0] xver_rx_header;
  logic       xver_rx_header_valid;
  logic       xver_rx_gearbox_slip;
  logic       o_block_lock;
  logic [7:0] o_slip_count;

  modport master (
    output xver_rx_header,
    output xver_rx_header_valid,
    input  xver_rx_gearbox_slip,
    input  o_block_lock,
    input  o_slip_count
  );

  modport slave (
    input  xver_rx_header,
    input  xver_rx_header_valid,
    output xver_rx_gearbox_slip,
    output o_block_lock,
    output o_slip_count
  );

endinterface

// File: rtl/reset_sync_n.sv
// ----------------------------------------------------------------------------
// reset_sync_n
//   Active-low reset: asserts asynchronously, releases synchronously after
//   two clock edges.
//   - clk        : destination clock
//   - arst_n     : raw asynchronous active-low reset
//   - rst_sync_n : reset for the clk domain
// ----------------------------------------------------------------------------
module reset_sync_n (
  input  logic clk,
  input  logic arst_n,
  output logic rst_sync_n
);

  logic meta;
  logic sync;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= 1'b1;
      sync <= meta;
    end
  end

  assign rst_sync_n = sync;

endmodule

// File: rtl/rx_block_lock_ctrl.sv
// ----------------------------------------------------------------------------
// rx_block_lock_ctrl
//   64b/66b receive block-lock state machine. Tests sync headers, requests
//   gearbox slips until alignment is found and qualifies the PCS receive
//   path with o_block_lock.
//   - xver_rx_clk : transceiver RX user clock
//   - i_reset_n   : asynchronous active-low reset
//   - bus         : header in, slip / lock / slip count out (slave modport)
// ----------------------------------------------------------------------------
module rx_block_lock_ctrl
  import eth_pcs_pkg::*;
#(
  parameter int SH_CNT_MAX       = 64,
  parameter int SH_INVALID_MAX   = 16,
  parameter int SLIP_WAIT_CYCLES = 32
) (
  input  logic                 xver_rx_clk,
  input  logic                 i_reset_n,
  rx_block_lock_ctrl_if.slave  bus
);

  localparam int SH_CNT_W  = $clog2(SH_CNT_MAX + 1);
  localparam int SH_INV_W  = $clog2(SH_INVALID_MAX + 1);
  localparam int WAIT_W    = $clog2(SLIP_WAIT_CYCLES + 1);

  localparam logic [SH_CNT_W-1:0] SH_CNT_LAST  = SH_CNT_W'(SH_CNT_MAX);
  localparam logic [SH_INV_W-1:0] SH_INV_LAST  = SH_INV_W'(SH_INVALID_MAX);
  localparam logic [WAIT_W-1:0]   WAIT_LOAD    = WAIT_W'(SLIP_WAIT_CYCLES);

  localparam logic [1:0] ST_RESET_CNT = 2'(RESET_CNT);
  localparam logic [1:0] ST_TEST_SH   = 2'(TEST_SH);
  localparam logic [1:0] ST_SLIP      = 2'(SLIP);
  localparam logic [1:0] ST_SLIP_WAIT = 2'(SLIP_WAIT);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic rst_n;

  reset_sync_n u_reset_sync (
    .clk        (xver_rx_clk),
    .arst_n     (i_reset_n),
    .rst_sync_n (rst_n)
  );

  logic [1:0]          state, state_nxt;
  logic [SH_CNT_W-1:0] sh_cnt, sh_cnt_nxt;
  logic [SH_INV_W-1:0] sh_invalid_cnt, sh_invalid_cnt_nxt;
  logic [WAIT_W-1:0]   wait_cnt, wait_cnt_nxt;
  logic                block_lock, block_lock_nxt;
  logic                slip, slip_nxt;
  logic [7:0]          slip_count, slip_count_nxt;

  // Post-increment counter values for the current header sample
  logic                hdr_bad;
  logic [SH_CNT_W-1:0] sh_cnt_inc;
  logic [SH_INV_W-1:0] sh_invalid_inc;

  assign hdr_bad        = !sh_is_valid(bus.xver_rx_header);
  assign sh_cnt_inc     = sh_cnt + SH_CNT_W'(1);
  assign sh_invalid_inc = sh_invalid_cnt + SH_INV_W'(hdr_bad);

  always_comb begin
    state_nxt          = state;
    sh_cnt_nxt         = sh_cnt;
    sh_invalid_cnt_nxt = sh_invalid_cnt;
    wait_cnt_nxt       = wait_cnt;
    block_lock_nxt     = block_lock;
    slip_nxt           = 1'b0;
    slip_count_nxt     = slip_count;

    case (state)
      ST_RESET_CNT: begin
        sh_cnt_nxt         = '0;
        sh_invalid_cnt_nxt = '0;
        state_nxt          = ST_TEST_SH;
      end

      ST_TEST_SH: begin
        if (bus.xver_rx_header_valid) begin
          sh_cnt_nxt         = sh_cnt_inc;
          sh_invalid_cnt_nxt = sh_invalid_inc;
          // Slip request and lock drop are registered together so both
          // appear in the cycle after the offending sample.
          if (hdr_bad && (!block_lock || sh_invalid_inc == SH_INV_LAST)) begin
            state_nxt      = ST_SLIP;
            slip_nxt       = 1'b1;
            block_lock_nxt = 1'b0;
          end else if (sh_cnt_inc == SH_CNT_LAST) begin
            if (sh_invalid_inc == '0) begin
              block_lock_nxt = 1'b1;
            end
            state_nxt = ST_RESET_CNT;
          end
        end
      end

      ST_SLIP: begin
        slip_count_nxt = sat_inc8(slip_count);
        wait_cnt_nxt   = WAIT_LOAD;
        state_nxt      = ST_SLIP_WAIT;
      end

      ST_SLIP_WAIT: begin
        // Headers are ignored here while the gearbox realigns
        if (wait_cnt <= WAIT_W'(1)) begin
          wait_cnt_nxt = '0;
          state_nxt    = ST_RESET_CNT;
        end else begin
          wait_cnt_nxt = wait_cnt - WAIT_W'(1);
        end
      end

      default: begin
        state_nxt = ST_RESET_CNT;
      end
    endcase
  end

  always_ff @(posedge xver_rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_RESET_CNT;
      sh_cnt         <= '0;
      sh_invalid_cnt <= '0;
      wait_cnt       <= '0;
      block_lock     <= 1'b0;
      slip           <= 1'b0;
      slip_count     <= 8'd0;
    end else begin
      state          <= state_nxt;
      sh_cnt         <= sh_cnt_nxt;
      sh_invalid_cnt <= sh_invalid_cnt_nxt;
      wait_cnt       <= wait_cnt_nxt;
      block_lock     <= block_lock_nxt;
      slip           <= slip_nxt;
      slip_count     <= slip_count_nxt;
    end
  end

  assign bus.xver_rx_gearbox_slip = slip;
  assign bus.o_block_lock         = block_lock;
  assign bus.o_slip_count         = slip_count;

endmodule

// File: tb/tb_rx_block_lock_ctrl.sv
// ----------------------------------------------------------------------------
// tb_rx_block_lock_ctrl
//   Self-checking bench for rx_block_lock_ctrl. Each driven cycle pushes the
//   expected registered outputs onto a scoreboard queue; they are popped and
//   compared one clock later, 1 time unit after the active edge.
// ----------------------------------------------------------------------------
module tb_rx_block_lock_ctrl;

  localparam int WAIT_CYC = 32;
  // Cycles from the slip edge until the first header is sampled again:
  // SLIP (1) + SLIP_WAIT (32) + RESET_CNT (1)
  localparam int IGNORE_CYC = WAIT_CYC + 2;

  logic xver_rx_clk;
  logic i_reset_n;

  rx_block_lock_ctrl_if bus ();

  rx_block_lock_ctrl #(
    .SH_CNT_MAX       (64),
    .SH_INVALID_MAX   (16),
    .SLIP_WAIT_CYCLES (WAIT_CYC)
  ) dut (
    .xver_rx_clk (xver_rx_clk),
    .i_reset_n   (i_reset_n),
    .bus         (bus)
  );

  initial xver_rx_clk = 1'b0;
  always #5 xver_rx_clk = ~xver_rx_clk;

  typedef struct {
    logic  slip;
    logic  lock;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Drive one cycle, queue its expected outputs, then pop and compare them
  // once the DUT has registered the sample.
  task automatic step(input logic [1:0] hdr, input logic vld,
                      input logic es, input logic el, input string tag);
    exp_t e;
    bus.xver_rx_header       = hdr;
    bus.xver_rx_header_valid = vld;
    e.slip = es;
    e.lock = el;
    e.tag  = tag;
    sb.push_back(e);
    @(posedge xver_rx_clk);
    #1;
    e = sb.pop_front();
    total++;
    if (bus.xver_rx_gearbox_slip !== e.slip) begin
      bad++;
      $display("FAIL %s slip: got %b want %b at %0t", e.tag,
               bus.xver_rx_gearbox_slip, e.slip, $time);
    end
    total++;
    if (bus.o_block_lock !== e.lock) begin
      bad++;
      $display("FAIL %s lock: got %b want %b at %0t", e.tag,
               bus.o_block_lock, e.lock, $time);
    end
  endtask

  task automatic apply_reset();
    i_reset_n = 1'b0;
    bus.xver_rx_header       = 2'b00;
    bus.xver_rx_header_valid = 1'b0;
    repeat (2) @(posedge xver_rx_clk);
    #1;
    i_reset_n = 1'b1;
    for (int i = 0; i < 5; i++) step(2'b00, 1'b0, 1'b0, 1'b0, "post_reset_idle");
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    bus.xver_rx_header       = 2'b11;
    bus.xver_rx_header_valid = 1'b1;
    repeat (3) @(posedge xver_rx_clk);
    #1;
    total++;
    if (bus.xver_rx_gearbox_slip !== 1'b0) begin
      bad++; $display("FAIL reset_slip: got %b want 0", bus.xver_rx_gearbox_slip);
    end
    total++;
    if (bus.o_block_lock !== 1'b0) begin
      bad++; $display("FAIL reset_lock: got %b want 0", bus.o_block_lock);
    end
    total++;
    if (bus.o_slip_count !== 8'd0) begin
      bad++; $display("FAIL reset_count: got %0d want 0", bus.o_slip_count);
    end
    apply_reset();
  endtask

  task automatic test_clean_alignment();
    for (int i = 0; i < 64; i++)
      step(2'b01, 1'b1, 1'b0, (i == 63), "clean_align");
    total++;
    if (bus.o_slip_count !== 8'd0) begin
      bad++; $display("FAIL clean_count: got %0d want 0", bus.o_slip_count);
    end
    // RESET_CNT cycle that follows a completed window
    step(2'b01, 1'b0, 1'b0, 1'b1, "clean_window_end");
  endtask

  task automatic test_locked_errors();
    logic [1:0] h;
    // 15 invalid + 49 valid samples: lock must hold
    for (int i = 0; i < 64; i++) begin
      h = (i < 15) ? ((i % 2) ? 2'b11 : 2'b00) : ((i % 2) ? 2'b10 : 2'b01);
      step(h, 1'b1, 1'b0, 1'b1, "locked_15_bad");
    end
    step(2'b01, 1'b0, 1'b0, 1'b1, "locked_window_end");
    // 16 invalid within the first 20 samples; the 16th is sample index 18
    for (int i = 0; i < 19; i++) begin
      h = ((i % 5) == 4) ? 2'b10 : 2'b00;
      step(h, 1'b1, (i == 18), (i != 18), "locked_16_bad");
    end
    step(2'b01, 1'b1, 1'b0, 1'b0, "after_lock_drop");
    total++;
    if (bus.o_slip_count !== 8'd1) begin
      bad++; $display("FAIL locked_drop_count: got %0d want 1", bus.o_slip_count);
    end
  endtask

  task automatic test_misaligned_start();
    apply_reset();
    step(2'b11, 1'b1, 1'b1, 1'b0, "misalign_slip");
    // Invalid headers presented with valid=1 must be ignored while waiting
    for (int i = 0; i < IGNORE_CYC; i++)
      step(2'b11, 1'b1, 1'b0, 1'b0, "misalign_wait");
    total++;
    if (bus.o_slip_count !== 8'd1) begin
      bad++; $display("FAIL misalign_count: got %0d want 1", bus.o_slip_count);
    end
    for (int i = 0; i < 64; i++)
      step(2'b10, 1'b1, 1'b0, (i == 63), "misalign_relock");
  endtask

  task automatic test_gapped_valid();
    apply_reset();
    // 64 samples spread over 128 cycles; lock after the 64th sample (i=126)
    for (int i = 0; i < 128; i++)
      step(2'b01, ((i % 2) == 0), 1'b0, (i >= 126), "gapped_valid");
  endtask

  task automatic test_reset_mid_lock();
    apply_reset();
    for (int i = 0; i < 64; i++)
      step(2'b01, 1'b1, 1'b0, (i == 63), "midlock_prelock");
    i_reset_n = 1'b0;
    #1;
    total++;
    if (bus.o_block_lock !== 1'b0) begin
      bad++; $display("FAIL midlock_async_drop: got %b want 0", bus.o_block_lock);
    end
    total++;
    if (bus.xver_rx_gearbox_slip !== 1'b0) begin
      bad++; $display("FAIL midlock_async_slip: got %b want 0", bus.xver_rx_gearbox_slip);
    end
    repeat (2) @(posedge xver_rx_clk);
    #1;
    i_reset_n = 1'b1;
    for (int i = 0; i < 5; i++) step(2'b00, 1'b0, 1'b0, 1'b0, "midlock_release");
    for (int i = 0; i < 64; i++)
      step(2'b01, 1'b1, 1'b0, (i == 63), "midlock_relock");
  endtask

  task automatic test_saturation();
    int want;
    apply_reset();
    for (int k = 0; k < 300; k++) begin
      step(2'b00, 1'b1, 1'b1, 1'b0, "sat_slip");
      for (int i = 0; i < IGNORE_CYC; i++)
        step(2'b00, 1'b0, 1'b0, 1'b0, "sat_wait");
      want = (k + 1 > 255) ? 255 : k + 1;
      total++;
      if (bus.o_slip_count !== 8'(want)) begin
        bad++; $display("FAIL sat_count: got %0d want %0d", bus.o_slip_count, want);
      end
    end
  endtask

  initial begin
    i_reset_n                = 1'b0;
    bus.xver_rx_header       = 2'b00;
    bus.xver_rx_header_valid = 1'b0;
    test_reset();
    test_clean_alignment();
    test_locked_errors();
    test_misaligned_start();
    test_gapped_valid();
    test_reset_mid_lock();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
